// File: rtl/mem_reinit_pkg.sv
// Shared types for the memory reinit controller: FSM state encoding and
// the default checksum width.
package mem_reinit_pkg;

   localparam int CSUM_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_TAIL,
      ST_CHECK,
      ST_DONE
   } reinit_state_t;

endpackage

// File: rtl/mem_reinit_ctrl_if.sv
// Input word stream plus the write/read ports of the simple-dual-port memory.
// The master side is the controller; the slave side is the source and the RAM.
interface mem_reinit_ctrl_if #(
   parameter int WID_MEM = 8
);
   logic               s_valid;
   logic               s_ready;
   logic [WID_MEM-1:0] s_data;
   logic               mem_we;
   logic [31:0]        mem_waddr;
   logic [WID_MEM-1:0] mem_din;
   logic [31:0]        mem_raddr;
   logic [WID_MEM-1:0] mem_dout;

   modport master (
      input  s_valid, s_data, mem_dout,
      output s_ready, mem_we, mem_waddr, mem_din, mem_raddr
   );

   modport slave (
      output s_valid, s_data, mem_dout,
      input  s_ready, mem_we, mem_waddr, mem_din, mem_raddr
   );
endinterface

// File: rtl/csum_acc.sv
// Wrapping additive checksum: clear has priority over enable, and each enabled
// word is zero-extended and summed modulo 2^CSUM_W.
module csum_acc
   import mem_reinit_pkg::*;
#(
   parameter int WID_MEM = 8,
   parameter int CSUM_W  = CSUM_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [WID_MEM-1:0] data_i,
   output logic [CSUM_W-1:0]  sum_o
);

   logic [CSUM_W-1:0] sum_q, sum_d;

   // NOTE: sum_d gets a default before the ifs so no path leaves it unassigned (no latch).
   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = '0;
      end else if (en_i) begin
         sum_d = sum_q + CSUM_W'(data_i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/memory.sv
// Single-clock simple-dual-port RAM with a registered read port (one-cycle latency).
module memory #(
   parameter int WID_MEM   = 8,
   parameter int DEPTH_MEM = 16,
   parameter int AW        = $clog2(DEPTH_MEM)
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [AW-1:0]      waddr_i,
   input  logic [WID_MEM-1:0] din_i,
   input  logic [AW-1:0]      raddr_i,
   output logic [WID_MEM-1:0] dout_o
);

   logic [WID_MEM-1:0] mem_q [DEPTH_MEM];
   logic [WID_MEM-1:0] dout_q;

   // NOTE: the array has no reset so it maps onto block RAM; contents survive controller resets.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= din_i;
      end
      dout_q <= mem_q[raddr_i];
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/mem_reinit_ctrl.sv
// Writes DEPTH_MEM streamed words into the RAM, reads them all back and
// reports whether the readback checksum matches the written one.
module mem_reinit_ctrl
   import mem_reinit_pkg::*;
#(
   parameter int WID_MEM   = 8,
   parameter int DEPTH_MEM = 4096,
   parameter int CSUM_W    = CSUM_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   mem_reinit_ctrl_if.master        bus,
   output logic                     busy,
   output logic                     done,
   output logic                     pass
);

   localparam int              PTR_W = $clog2(DEPTH_MEM);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH_MEM - 1);

   reinit_state_t     state_q;
   logic [PTR_W-1:0]  wptr_q;
   logic [PTR_W-1:0]  rptr_q;
   logic              rd_vld_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;

   logic              start_acc;
   logic              wr_accept;
   logic [CSUM_W-1:0] wr_sum;
   logic [CSUM_W-1:0] rd_sum;

   assign start_acc = (state_q == ST_IDLE) && start;
   assign wr_accept = (state_q == ST_WRITE) && bus.s_valid;

   // Write side is combinational so a word is stored in the cycle it is accepted.
   assign bus.s_ready   = (state_q == ST_WRITE);
   assign bus.mem_we    = wr_accept;
   assign bus.mem_waddr = wr_accept ? 32'(wptr_q) : '0;
   assign bus.mem_din   = wr_accept ? bus.s_data : '0;
   assign bus.mem_raddr = 32'(rptr_q);

   assign busy = busy_q;
   assign done = done_q;
   assign pass = pass_q;

   csum_acc #(.WID_MEM(WID_MEM), .CSUM_W(CSUM_W)) u_wr_csum (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (start_acc),
      .en_i   (wr_accept),
      .data_i (bus.s_data),
      .sum_o  (wr_sum)
   );

   csum_acc #(.WID_MEM(WID_MEM), .CSUM_W(CSUM_W)) u_rd_csum (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (start_acc),
      .en_i   (rd_vld_q),
      .data_i (bus.mem_dout),
      .sum_o  (rd_sum)
   );

   // NOTE: all state updates use <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wptr_q   <= '0;
         rptr_q   <= '0;
         rd_vld_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         rd_vld_q <= (state_q == ST_READ);
         done_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_WRITE;
                  wptr_q  <= '0;
                  rptr_q  <= '0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_WRITE: begin
               if (bus.s_valid) begin
                  if (wptr_q == LAST) begin
                     state_q <= ST_READ;
                     wptr_q  <= '0;
                  end else begin
                     wptr_q <= wptr_q + 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (rptr_q == LAST) begin
                  state_q <= ST_TAIL;
                  rptr_q  <= '0;
               end else begin
                  rptr_q <= rptr_q + 1'b1;
               end
            end
            // Last read word lands in TAIL and is summed at its closing edge.
            ST_TAIL: state_q <= ST_CHECK;
            ST_CHECK: begin
               pass_q  <= (wr_sum == rd_sum);
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_reinit_ctrl.sv
// Bench for mem_reinit_ctrl: a phase-timeline model predicts every output each
// cycle, and directed passes pin done latency, pass/fail and checksum values.
module tb_mem_reinit_ctrl;

   localparam int WID   = 8;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic inj = 1'b0;
   logic chk_en = 1'b0;
   logic busy, done, pass;
   logic busy8, done8, pass8;

   always #5 clk = ~clk;

   mem_reinit_ctrl_if #(.WID_MEM(WID)) bus ();
   mem_reinit_ctrl_if #(.WID_MEM(WID)) bus8 ();

   mem_reinit_ctrl #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .CSUM_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .busy(busy), .done(done), .pass(pass)
   );

   // Word 5 can be overwritten with 0xFF through the write port while the DUT is reading.
   logic       m_we;
   logic [3:0] m_waddr;
   logic [7:0] m_din;
   assign m_we    = inj | bus.mem_we;
   assign m_waddr = inj ? 4'd5 : bus.mem_waddr[3:0];
   assign m_din   = inj ? 8'hFF : bus.mem_din;

   memory #(.WID_MEM(WID), .DEPTH_MEM(DEPTH)) u_mem (
      .clk(clk), .we_i(m_we), .waddr_i(m_waddr), .din_i(m_din),
      .raddr_i(bus.mem_raddr[3:0]), .dout_o(bus.mem_dout)
   );

   // 8-bit checksum instance: shares control, always fed 0xFF words.
   assign bus8.s_valid = bus.s_valid;
   assign bus8.s_data  = 8'hFF;

   mem_reinit_ctrl #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .CSUM_W(8)) dut8 (
      .clk(clk), .reset(reset), .start(start), .bus(bus8),
      .busy(busy8), .done(done8), .pass(pass8)
   );

   memory #(.WID_MEM(WID), .DEPTH_MEM(DEPTH)) u_mem8 (
      .clk(clk), .we_i(bus8.mem_we), .waddr_i(bus8.mem_waddr[3:0]), .din_i(bus8.mem_din),
      .raddr_i(bus8.mem_raddr[3:0]), .dout_o(bus8.mem_dout)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: t is the cycle number of the current pass (1 = first WRITE cycle, -1 = idle);
   // wend is the cycle in which the last word was accepted (0 while still writing).
   int          t = -1;
   int          acc_m = 0;
   int          wend = 0;
   logic [7:0]  mm [DEPTH];
   logic [15:0] wsum_m = '0;
   logic        exp_pass = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         t = -1;
         exp_pass = 1'b0;
      end else begin
         if (inj) mm[5] = 8'hFF;
         if (t < 0) begin
            if (start) begin
               t = 1; acc_m = 0; wend = 0; wsum_m = '0; exp_pass = 1'b0;
            end
         end else begin
            if (wend == 0 && bus.s_valid) begin
               mm[acc_m] = bus.s_data;
               wsum_m += 16'(bus.s_data);
               acc_m++;
               if (acc_m == DEPTH) wend = t;
            end
            if (wend != 0 && t == wend + DEPTH + 2) begin
               logic [15:0] rs;
               rs = '0;
               for (int k = 0; k < DEPTH; k++) rs += 16'(mm[k]);
               exp_pass = (rs == wsum_m);
            end
            if (wend != 0 && t == wend + DEPTH + 3) t = -1;
            else t++;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         if (reset) begin
            check("rst_s_ready", bus.s_ready, 0);
            check("rst_mem_we", bus.mem_we, 0);
            check("rst_waddr", bus.mem_waddr, 0);
            check("rst_din", bus.mem_din, 0);
            check("rst_raddr", bus.mem_raddr, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_pass", pass, 0);
         end else begin
            logic act, wr, rd, dn;
            act = (t > 0);
            wr  = act && (wend == 0);
            rd  = act && (wend != 0) && (t <= wend + DEPTH);
            dn  = act && (wend != 0) && (t == wend + DEPTH + 3);
            check("s_ready", bus.s_ready, wr);
            check("mem_we", bus.mem_we, wr && bus.s_valid);
            if (wr && bus.s_valid) begin
               check("mem_waddr", bus.mem_waddr, acc_m);
               check("mem_din", bus.mem_din, bus.s_data);
            end
            if (rd) check("mem_raddr", bus.mem_raddr, t - wend - 1);
            check("busy", busy, act);
            check("done", done, dn);
            check("pass", pass, exp_pass);
            check("busy8", busy8, act);
            check("done8", done8, dn);
         end
      end
   end

   // One pass: start in IDLE, feed DEPTH words, optionally stall / corrupt / poke start.
   task automatic run_pass(input bit stall, input bit do_inj, input bit ff_data,
                           input bit poke_start, output int dcyc, output int npulse);
      int acc;
      bit rdy;
      bit inj_done;
      acc = 0; inj_done = 1'b0; dcyc = 0; npulse = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         bus.s_valid = (acc < DEPTH) && (!stall || (c % 2 == 1));
         bus.s_data  = ff_data ? 8'hFF : 8'(acc);
         inj = do_inj && (acc == DEPTH) && !inj_done;
         if (inj) inj_done = 1'b1;
         start = poke_start && (c == 5);
         @(negedge clk);
         rdy = bus.s_ready;
         if (done) begin
            npulse++;
            if (dcyc == 0) dcyc = c;
            if (poke_start) start = 1'b1;
         end
         @(posedge clk); #1;
         if (bus.s_valid && rdy) acc++;
         if (dcyc != 0 && c >= dcyc + 4) break;
      end
      bus.s_valid = 1'b0; inj = 1'b0; start = 1'b0;
      if (dcyc == 0) check("done_timeout", 0, 1);
   endtask

   initial begin
      int d, n;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);
      @(posedge clk); #1;

      // Incrementing data, no stalls.
      run_pass(0, 0, 0, 0, d, n);
      check("t1_done_cycle", d, 35);
      check("t1_pulses", n, 1);
      check("t1_pass", pass, 1);
      check("t1_wr_sum", dut.wr_sum, 16'h0078);
      check("t1_rd_sum", dut.rd_sum, 16'h0078);

      // Same data, s_valid low every other cycle.
      run_pass(1, 0, 0, 0, d, n);
      check("t2_done_cycle", d, 50);
      check("t2_pass", pass, 1);
      for (int k = 0; k < DEPTH; k++) check("t2_mem_word", u_mem.mem_q[k], k);

      // Word 5 overwritten with 0xFF before it is read back.
      run_pass(0, 1, 0, 0, d, n);
      check("t3_done_cycle", d, 35);
      check("t3_pulses", n, 1);
      check("t3_pass", pass, 0);
      check("t3_wr_sum", dut.wr_sum, 16'h0078);
      check("t3_rd_sum", dut.rd_sum, 16'h0172);

      // All-0xFF words; the 8-bit instance wraps to 0xF0.
      run_pass(0, 0, 1, 0, d, n);
      check("t4_pass", pass, 1);
      check("t4_wr_sum16", dut.wr_sum, 16'h0FF0);
      check("t4_rd_sum16", dut.rd_sum, 16'h0FF0);
      check("t4_wr_sum8", dut8.wr_sum, 8'hF0);
      check("t4_rd_sum8", dut8.rd_sum, 8'hF0);
      check("t4_pass8", pass8, 1);

      // Asynchronous reset in the middle of READ, then a clean pass.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bus.s_valid = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         bus.s_data = 8'(k);
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("t5_async_busy", busy, 0);
      check("t5_async_raddr", bus.mem_raddr, 0);
      check("t5_async_pass", pass, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      run_pass(0, 0, 0, 0, d, n);
      check("t5_done_cycle", d, 35);
      check("t5_pass", pass, 1);

      // start pulsed during WRITE and during DONE is ignored.
      run_pass(0, 0, 0, 1, d, n);
      check("t6_done_cycle", d, 35);
      check("t6_pulses", n, 1);
      repeat (3) @(posedge clk);
      #1;
      check("t6_stays_idle", busy, 0);
      run_pass(0, 0, 0, 0, d, n);
      check("t6_next_done_cycle", d, 35);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
